// File: rtl/kpn_pkg.sv
// Shared types and constants for the fixed-point KPN pipeline channels.
package kpn_pkg;

    localparam int KPN_DATA_WIDTH   = 16;
    localparam int ZERO_COUNT_WIDTH = 8;

    typedef logic [KPN_DATA_WIDTH-1:0] kpn_token_t;

    localparam logic [ZERO_COUNT_WIDTH-1:0] ZERO_COUNT_MAX = {ZERO_COUNT_WIDTH{1'b1}};

    // Saturating increment used by the monitoring counters.
    function automatic logic [ZERO_COUNT_WIDTH-1:0] sat_inc(input logic [ZERO_COUNT_WIDTH-1:0] val);
        if (val == ZERO_COUNT_MAX) begin
            return val;
        end else begin
            return val + {{(ZERO_COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/kpn_fifo.sv
// Synchronous FIFO channel for KPN tokens; a push is ignored when full and a
// same-cycle pop does not free room for it.
module kpn_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/divider_input_join.sv
// Joins dividend and divisor token streams into pairs for the divider, flagging
// and counting zero divisors.
module divider_input_join
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_1_data,
    input  logic                        in_1_valid,
    output logic                        in_1_ready,
    input  logic [DATA_WIDTH-1:0]       in_2_data,
    input  logic                        in_2_valid,
    output logic                        in_2_ready,
    output logic [DATA_WIDTH-1:0]       entry_1,
    output logic [DATA_WIDTH-1:0]       entry_2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        div_by_zero,
    output logic [ZERO_COUNT_WIDTH-1:0] zero_count
);

    logic [DATA_WIDTH-1:0]       head_1_s, head_2_s;
    logic                        full_1_s, full_2_s;
    logic                        empty_1_s, empty_2_s;
    logic                        load_s;
    logic                        zero_s;

    logic [DATA_WIDTH-1:0]       entry_1_q, entry_1_d;
    logic [DATA_WIDTH-1:0]       entry_2_q, entry_2_d;
    logic                        out_valid_q, out_valid_d;
    logic                        div_by_zero_q, div_by_zero_d;
    logic [ZERO_COUNT_WIDTH-1:0] zero_count_q, zero_count_d;

    assign in_1_ready = !full_1_s && !reset;
    assign in_2_ready = !full_2_s && !reset;

    kpn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_dividend (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_1_valid && in_1_ready),
        .data_i  (in_1_data),
        .pop_i   (load_s),
        .data_o  (head_1_s),
        .full_o  (full_1_s),
        .empty_o (empty_1_s)
    );

    kpn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_divisor (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_2_valid && in_2_ready),
        .data_i  (in_2_data),
        .pop_i   (load_s),
        .data_o  (head_2_s),
        .full_o  (full_2_s),
        .empty_o (empty_2_s)
    );

    // A new pair loads only when both heads exist and the output slot frees up.
    assign load_s = !empty_1_s && !empty_2_s && (!out_valid_q || out_ready);
    assign zero_s = (head_2_s == {DATA_WIDTH{1'b0}});

    // Output register and zero-counter next-state.
    always_comb begin
        entry_1_d     = entry_1_q;
        entry_2_d     = entry_2_q;
        out_valid_d   = out_valid_q;
        div_by_zero_d = div_by_zero_q;
        zero_count_d  = zero_count_q;
        if (load_s) begin
            entry_1_d     = head_1_s;
            entry_2_d     = head_2_s;
            out_valid_d   = 1'b1;
            div_by_zero_d = zero_s;
            if (zero_s) begin
                zero_count_d = sat_inc(zero_count_q);
            end else begin
                zero_count_d = zero_count_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output pair, flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_1_q     <= {DATA_WIDTH{1'b0}};
            entry_2_q     <= {DATA_WIDTH{1'b0}};
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            zero_count_q  <= {ZERO_COUNT_WIDTH{1'b0}};
        end else begin
            entry_1_q     <= entry_1_d;
            entry_2_q     <= entry_2_d;
            out_valid_q   <= out_valid_d;
            div_by_zero_q <= div_by_zero_d;
            zero_count_q  <= zero_count_d;
        end
    end

    assign entry_1     = entry_1_q;
    assign entry_2     = entry_2_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = div_by_zero_q;
    assign zero_count  = zero_count_q;

endmodule

// File: tb/tb_divider_input_join.sv
// Directed-vector bench for divider_input_join with hand-computed expectations.
module tb_divider_input_join;

    logic        clk;
    logic        reset;
    logic [15:0] in_1_data;
    logic        in_1_valid;
    logic        in_1_ready;
    logic [15:0] in_2_data;
    logic        in_2_valid;
    logic        in_2_ready;
    logic [15:0] entry_1;
    logic [15:0] entry_2;
    logic        out_valid;
    logic        out_ready;
    logic        div_by_zero;
    logic [7:0]  zero_count;

    int pass_cnt;
    int total_cnt;
    int bubbles;

    divider_input_join #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_1_data   (in_1_data),
        .in_1_valid  (in_1_valid),
        .in_1_ready  (in_1_ready),
        .in_2_data   (in_2_data),
        .in_2_valid  (in_2_valid),
        .in_2_ready  (in_2_ready),
        .entry_1     (entry_1),
        .entry_2     (entry_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_by_zero (div_by_zero),
        .zero_count  (zero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [15:0] d1, input logic v2, input logic [15:0] d2);
        in_1_valid = v1;
        in_1_data  = d1;
        in_2_valid = v2;
        in_2_data  = d2;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        step();
        step();

        // Reset state
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_e1", {16'd0, entry_1}, 32'd0);
        check_eq("rst_zc", {24'd0, zero_count}, 32'd0);
        check_eq("rst_rdy1", {31'd0, in_1_ready}, 32'd0);
        check_eq("rst_rdy2", {31'd0, in_2_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rel_rdy1", {31'd0, in_1_ready}, 32'd1);
        check_eq("rel_rdy2", {31'd0, in_2_ready}, 32'd1);

        // Basic pair
        drive(1'b1, 16'd20, 1'b1, 16'd10);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("basic_lat1", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("basic_valid", {31'd0, out_valid}, 32'd1);
        check_eq("basic_e1", {16'd0, entry_1}, 32'd20);
        check_eq("basic_e2", {16'd0, entry_2}, 32'd10);
        check_eq("basic_dbz", {31'd0, div_by_zero}, 32'd0);
        step();
        check_eq("basic_consumed", {31'd0, out_valid}, 32'd0);

        // Skewed arrival
        drive(1'b1, 16'd90, 1'b0, 16'd0);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("skew_wait", {31'd0, out_valid}, 32'd0);
        end
        drive(1'b0, 16'd0, 1'b1, 16'd10);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("skew_lat1", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("skew_valid", {31'd0, out_valid}, 32'd1);
        check_eq("skew_e1", {16'd0, entry_1}, 32'd90);
        check_eq("skew_e2", {16'd0, entry_2}, 32'd10);
        step();
        check_eq("skew_consumed", {31'd0, out_valid}, 32'd0);

        // Backpressure: one pair in the output register plus four queued
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 1'b1, 16'(10 + i));
            step();
        end
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("bp_rdy1", {31'd0, in_1_ready}, 32'd0);
        check_eq("bp_rdy2", {31'd0, in_2_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_v", {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_e1", {16'd0, entry_1}, 32'd1);
            check_eq("bp_hold_e2", {16'd0, entry_2}, 32'd11);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check_eq("bp_drain_v", {31'd0, out_valid}, 32'd1);
            check_eq("bp_drain_e1", {16'd0, entry_1}, 32'(k));
            check_eq("bp_drain_e2", {16'd0, entry_2}, 32'(10 + k));
            if (k == 2) begin
                check_eq("bp_rdy_back", {31'd0, in_1_ready}, 32'd1);
            end
        end
        step();
        check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

        // Zero divisor
        drive(1'b1, 16'd15, 1'b1, 16'd0);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        step();
        check_eq("zero_valid", {31'd0, out_valid}, 32'd1);
        check_eq("zero_e1", {16'd0, entry_1}, 32'd15);
        check_eq("zero_e2", {16'd0, entry_2}, 32'd0);
        check_eq("zero_dbz", {31'd0, div_by_zero}, 32'd1);
        check_eq("zero_cnt1", {24'd0, zero_count}, 32'd1);
        step();

        // 300 zero-divisor pairs streamed back to back; counter saturates
        bubbles = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'd7, 1'b1, 16'd0);
            step();
            if (i >= 1 && !out_valid) bubbles++;
            if (i == 99) check_eq("zero_cnt100", {24'd0, zero_count}, 32'd100);
        end
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("zero_bubbles", 32'(bubbles), 32'd0);
        step();
        check_eq("zero_sat", {24'd0, zero_count}, 32'd255);
        check_eq("zero_sat_dbz", {31'd0, div_by_zero}, 32'd1);
        step();
        check_eq("zero_drained", {31'd0, out_valid}, 32'd0);
        check_eq("zero_sat_hold", {24'd0, zero_count}, 32'd255);

        // Streaming with distinct values: strict order, no bubbles
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(100 + i), 1'b1, 16'(200 + i));
            step();
            if (i >= 1) begin
                check_eq("stream_v", {31'd0, out_valid}, 32'd1);
                check_eq("stream_e1", {16'd0, entry_1}, 32'(100 + i - 1));
                check_eq("stream_e2", {16'd0, entry_2}, 32'(200 + i - 1));
            end
        end
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        step();
        check_eq("stream_last", {16'd0, entry_1}, 32'd119);
        step();

        // Reset mid-stream with three tokens queued and a pair presented
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(31 + i), 1'b1, 16'(41 + i));
            step();
        end
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("mid_pre_v", {31'd0, out_valid}, 32'd1);
        check_eq("mid_pre_e1", {16'd0, entry_1}, 32'd31);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_v", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_e1", {16'd0, entry_1}, 32'd0);
        check_eq("mid_rst_e2", {16'd0, entry_2}, 32'd0);
        check_eq("mid_rst_zc", {24'd0, zero_count}, 32'd0);
        check_eq("mid_rst_rdy", {31'd0, in_1_ready}, 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("mid_no_stale", {31'd0, out_valid}, 32'd0);
        end
        drive(1'b1, 16'd77, 1'b1, 16'd3);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        step();
        check_eq("mid_fresh_v", {31'd0, out_valid}, 32'd1);
        check_eq("mid_fresh_e1", {16'd0, entry_1}, 32'd77);
        check_eq("mid_fresh_e2", {16'd0, entry_2}, 32'd3);
        step();
        check_eq("mid_fresh_done", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
